// File: rtl/ripple_add_seq.sv
// Purpose : multi-cycle WIDTH-bit adder that drives an external 2-bit ripple
//           slice, one slice per clock, LSB slice first.
// Latency : start sampled at edge E -> done high in the cycle after E+NSLICE.
// Backpressure: none; start is only looked at in IDLE, requests in RUN/DONE
//           are dropped without queuing.
//
// Ports
//   clk, resetN          clock, asynchronous active-low reset
//   start, a, b, carryIn add request and operands (captured on acceptance)
//   sliceA/B/Cin         operands/carry for the external 2-bit adder (0 outside RUN)
//   sliceSum/Cout        combinational result from the external adder
//   busy, done           busy in RUN and DONE; done is a one-cycle result strobe
//   sum, carry           registered result, updated only when DONE is entered
//   overflow             signed overflow; only built when the macro
//                        RIPPLE_ADD_SEQ_OVERFLOW_EN is defined, else tied to 0
module ripple_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryIn,
  output logic [1:0]       sliceA,
  output logic [1:0]       sliceB,
  output logic             sliceCin,
  input  logic [1:0]       sliceSum,
  input  logic             sliceCout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int NSLICE = WIDTH / 2;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] rega_q, rega_d;
  logic [WIDTH-1:0] regb_q, regb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cy_q, cy_d;
  logic             carry_q, carry_d;

  logic             last_slice;
  logic [KW:0]      bit_pos;     // 2*k, the LSB position of the current slice
  logic [1:0]       a_sel;
  logic [1:0]       b_sel;
  logic [WIDTH-1:0] slice_mask;

  assign last_slice = (k_q == KW'(NSLICE - 1));
  assign bit_pos    = {k_q, 1'b0};
  assign a_sel      = 2'(rega_q >> bit_pos);
  assign b_sel      = 2'(regb_q >> bit_pos);
  assign slice_mask = WIDTH'(2'b11) << bit_pos;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    rega_d  = rega_q;
    regb_d  = regb_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cy_d    = cy_q;
    carry_d = carry_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          rega_d  = a;
          regb_d  = b;
          cy_d    = carryIn;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = (acc_q & ~slice_mask) | (WIDTH'(sliceSum) << bit_pos);
        cy_d  = sliceCout;
        k_d   = k_q + KW'(1);
        if (last_slice) begin
          // Publish the finished accumulator in the same edge that writes
          // its top slice, so sum never shows a partial result.
          sum_d   = acc_d;
          carry_d = sliceCout;
          k_d     = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      k_q     <= '0;
      rega_q  <= '0;
      regb_q  <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cy_q    <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      rega_q  <= rega_d;
      regb_q  <= regb_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cy_q    <= cy_d;
      carry_q <= carry_d;
    end
  end

  always_comb begin
    sliceA   = 2'b00;
    sliceB   = 2'b00;
    sliceCin = 1'b0;
    if (state_q == RUN) begin
      sliceA   = a_sel;
      sliceB   = b_sel;
      sliceCin = cy_q;
    end
  end

  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign carry = carry_q;

`ifdef RIPPLE_ADD_SEQ_OVERFLOW_EN
  logic ovf_q, ovf_d;
  logic top_cin;

  // Carry into the MSB is recovered from the MSB sum bit: s = a ^ b ^ cin.
  assign top_cin = rega_q[WIDTH-1] ^ regb_q[WIDTH-1] ^ acc_d[WIDTH-1];

  always_comb begin
    ovf_d = ovf_q;
    if ((state_q == RUN) && last_slice) begin
      ovf_d = top_cin ^ sliceCout;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_ripple_add_seq.sv
module tb_ripple_add_seq;

  localparam int WIDTH  = 8;
  localparam int NSLICE = WIDTH / 2;

  logic             clk;
  logic             resetN;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carryIn;
  logic [1:0]       sliceA;
  logic [1:0]       sliceB;
  logic             sliceCin;
  logic [1:0]       sliceSum;
  logic             sliceCout;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             overflow;

  ripple_add_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .resetN    (resetN),
    .start     (start),
    .a         (a),
    .b         (b),
    .carryIn   (carryIn),
    .sliceA    (sliceA),
    .sliceB    (sliceB),
    .sliceCin  (sliceCin),
    .sliceSum  (sliceSum),
    .sliceCout (sliceCout),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry     (carry),
    .overflow  (overflow)
  );

  // External 2-bit ripple adder seen by the DUT.
  assign {sliceCout, sliceSum} = {1'b0, sliceA} + {1'b0, sliceB} + {2'b00, sliceCin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycle monitor: slice outputs must be quiet outside RUN, sum frozen inside RUN.
  logic [WIDTH-1:0] prev_sum;
  always @(negedge clk) begin
    if (!resetN) begin
      prev_sum = sum;
    end else begin
      if (busy && !done) begin
        chk("sum_stable_in_run", 32'(sum), 32'(prev_sum));
      end else begin
        chk("slice_zero_outside_run", {29'd0, sliceA, sliceB, sliceCin}, 32'd0);
      end
      prev_sum = sum;
    end
  end

  typedef struct {
    logic [WIDTH-1:0] va;
    logic [WIDTH-1:0] vb;
    logic             vcin;
    logic [WIDTH-1:0] esum;
    logic             ecarry;
    logic             eovf;
  } vec_t;

  function automatic logic ovf_exp(input logic v);
`ifdef RIPPLE_ADD_SEQ_OVERFLOW_EN
    return v;
`else
    return 1'b0 & v;
`endif
  endfunction

  // One complete add: start pulse, latency, busy width, result, done width.
  task automatic run_add(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                         input logic vcin, input logic [WIDTH-1:0] esum,
                         input logic ecarry, input logic eovf);
    int lat;
    int busy_cnt;
    @(negedge clk);
    a = va; b = vb; carryIn = vcin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); carryIn = 1'($urandom);
    busy_cnt = busy ? 1 : 0;
    lat = 0;
    while (!done && lat < 50) begin
      @(negedge clk);
      lat++;
      if (busy) busy_cnt++;
    end
    chk("latency", 32'(lat), 32'(NSLICE));
    chk("busy_cycles", 32'(busy_cnt), 32'(NSLICE + 1));
    chk("sum", 32'(sum), 32'(esum));
    chk("carry", 32'(carry), 32'(ecarry));
    chk("overflow", 32'(overflow), 32'(ovf_exp(eovf)));
    @(negedge clk);
    chk("done_one_cycle", {30'd0, done, busy}, 32'd0);
    chk("sum_held", 32'(sum), 32'(esum));
  endtask

  vec_t vecs[9];

  initial begin
    int lat;
    int seen;
    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};
    vecs[8] = '{8'hC0, 8'hC0, 1'b0, 8'h80, 1'b1, 1'b0};

    resetN = 1'b0; start = 1'b0; a = '0; b = '0; carryIn = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy_done", {30'd0, busy, done}, 32'd0);
    chk("reset_sum", 32'(sum), 32'd0);
    chk("reset_carry_ovf", {30'd0, carry, overflow}, 32'd0);
    chk("reset_slices", {29'd0, sliceA, sliceB, sliceCin}, 32'd0);
    resetN = 1'b1;

    // Idle with start low: nothing moves.
    a = 8'hFF; b = 8'hFF;
    repeat (3) @(negedge clk);
    chk("idle_hold", {21'd0, busy, done, carry, sum}, 32'd0);

    foreach (vecs[i]) begin
      run_add(vecs[i].va, vecs[i].vb, vecs[i].vcin,
              vecs[i].esum, vecs[i].ecarry, vecs[i].eovf);
    end

    // Second start in RUN and in DONE is dropped.
    @(negedge clk);
    a = 8'h10; b = 8'h20; carryIn = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 8'hFF; b = 8'hFF;  // start stays high through RUN
    lat = 0;
    while (!done && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("ign_latency", 32'(lat), 32'(NSLICE));
    chk("ign_sum", 32'(sum), 32'h30);
    chk("ign_carry", 32'(carry), 32'd0);
    // start still high for the DONE edge, then dropped.
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    chk("ign_no_second_add", 32'(seen), 32'd0);
    chk("ign_sum_held", 32'(sum), 32'h30);

    // Reset abort at k=2.
    @(negedge clk);
    a = 8'h5A; b = 8'h3C; carryIn = 1'b0; start = 1'b1;
    @(negedge clk);  // k=0
    start = 1'b0;
    @(negedge clk);  // k=1
    @(negedge clk);  // k=2
    #2 resetN = 1'b0;
    #1;
    chk("abort_busy_done", {30'd0, busy, done}, 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_carry_ovf", {30'd0, carry, overflow}, 32'd0);
    @(negedge clk);
    resetN = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    run_add(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout, expected finish");
    $fatal(1, "timeout");
  end

endmodule
